// File: rtl/imem_arbiter_pkg.sv
// Shared encodings for the instruction-memory arbiter and boot sequencer.
package imem_arbiter_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  localparam logic CHIP_ENABLE   = 1'b1;
  localparam logic CHIP_DISABLE  = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic ZERO_BIT      = 1'b0;

endpackage

// File: rtl/imem_arb_burst_cnt.sv
// Saturating count of consecutive loader grants taken while a fetch waits.
module imem_arb_burst_cnt #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             at_limit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != limit)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_limit = (cnt == limit);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory arbiter: fetch vs loader, boot gating, registered responses.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MAX_LOAD_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid,
  output logic              stallreq,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_done,
  output logic              ld_gnt,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  output logic              boot_done,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(MAX_LOAD_BURST + 1);

  arb_state_t state_q, state_d;
  logic       fetch_gnt;
  logic       at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == BOOT) && ld_done) begin
      state_d = RUN;
    end
  end

  // Grants are qualified by rst_n so nothing reaches memory while reset is held.
  always_comb begin
    ld_gnt    = 1'b0;
    fetch_gnt = 1'b0;
    if (rst_n) begin
      case (state_q)
        BOOT: ld_gnt = ld_req;
        RUN: begin
          if (ld_req && (!if_req || !at_limit)) begin
            ld_gnt = 1'b1;
          end else if (if_req) begin
            fetch_gnt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_ce    = CHIP_DISABLE;
    mem_we    = WRITE_DISABLE;
    mem_addr  = {ADDR_W{ZERO_BIT}};
    mem_wdata = {DATA_W{ZERO_BIT}};
    if (ld_gnt) begin
      mem_ce    = CHIP_ENABLE;
      mem_we    = ld_we ? WRITE_ENABLE : WRITE_DISABLE;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (fetch_gnt) begin
      mem_ce   = CHIP_ENABLE;
      mem_addr = if_addr;
    end
  end

  assign stallreq  = if_req & ~fetch_gnt;
  assign boot_done = (state_q == RUN);

  imem_arb_burst_cnt #(
    .CNT_W (CNT_W)
  ) u_burst_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (fetch_gnt | ~if_req),
    .inc      (ld_gnt & if_req),
    .limit    (CNT_W'(MAX_LOAD_BURST)),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid  <= 1'b0;
      ld_rvalid <= 1'b0;
      if_inst   <= '0;
      ld_rdata  <= '0;
    end else begin
      if_valid  <= fetch_gnt;
      ld_rvalid <= ld_gnt & ~ld_we;
      if (fetch_gnt) begin
        if_inst <= mem_rdata;
      end
      if (ld_gnt && !ld_we) begin
        ld_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: reference grant model, behavioural memory, response scoreboard.
module tb_imem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned MAXB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_inst;
  logic          if_valid;
  logic          stallreq;
  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_done;
  logic          ld_gnt;
  logic [DW-1:0] ld_rdata;
  logic          ld_rvalid;
  logic          boot_done;
  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  imem_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .MAX_LOAD_BURST (MAXB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_inst   (if_inst),
    .if_valid  (if_valid),
    .stallreq  (stallreq),
    .ld_req    (ld_req),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_wdata  (ld_wdata),
    .ld_done   (ld_done),
    .ld_gnt    (ld_gnt),
    .ld_rdata  (ld_rdata),
    .ld_rvalid (ld_rvalid),
    .boot_done (boot_done),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural memory driven only through the DUT's memory port.
  logic [DW-1:0] dmem [0:63];
  assign mem_rdata = dmem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_ce && mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
  end

  // Reference state.
  logic [DW-1:0] ref_mem [0:63];
  logic          m_run;
  int unsigned   m_cnt;
  logic          exp_if_v, exp_ld_v;
  logic [DW-1:0] if_q[$];
  logic [DW-1:0] ld_q[$];
  logic          obs_ld_gnt;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run    = 1'b0;
    m_cnt    = 0;
    exp_if_v = 1'b0;
    exp_ld_v = 1'b0;
    if_q.delete();
    ld_q.delete();
  endtask

  // One clock: drive, check combinational grant/mux, advance model, check responses.
  task automatic step(input logic ifr, input logic [AW-1:0] ia, input logic ldr,
                      input logic we, input logic [AW-1:0] la, input logic [DW-1:0] wd,
                      input logic done);
    logic          lg, fg;
    logic [DW-1:0] popped;
    @(negedge clk);
    if_req = ifr; if_addr = ia; ld_req = ldr; ld_we = we;
    ld_addr = la; ld_wdata = wd; ld_done = done;
    #1;
    if (m_run) begin
      lg = ldr && (!ifr || (m_cnt != MAXB));
      fg = ifr && !lg;
    end else begin
      lg = ldr;
      fg = 1'b0;
    end
    obs_ld_gnt = ld_gnt;
    check("ld_gnt",    32'(ld_gnt),   32'(lg));
    check("stallreq",  32'(stallreq), 32'(ifr && !fg));
    check("mem_ce",    32'(mem_ce),   32'(lg || fg));
    check("mem_we",    32'(mem_we),   32'(lg && we));
    check("mem_addr",  mem_addr,      lg ? la : (fg ? ia : '0));
    check("mem_wdata", mem_wdata,     lg ? wd : '0);
    if (fg) if_q.push_back(ref_mem[ia[7:2]]);
    if (lg && !we) ld_q.push_back(ref_mem[la[7:2]]);
    exp_if_v = fg;
    exp_ld_v = lg && !we;
    @(posedge clk);
    if (lg && we) ref_mem[la[7:2]] = wd;
    if (fg || !ifr) m_cnt = 0;
    else if (lg && (m_cnt < MAXB)) m_cnt++;
    if (!m_run && done) m_run = 1'b1;
    #1;
    check("if_valid",  32'(if_valid),  32'(exp_if_v));
    check("ld_rvalid", 32'(ld_rvalid), 32'(exp_ld_v));
    check("boot_done", 32'(boot_done), 32'(m_run));
    if (if_valid && if_q.size() > 0) begin
      popped = if_q.pop_front();
      check("if_inst", if_inst, popped);
    end
    if (ld_rvalid && ld_q.size() > 0) begin
      popped = ld_q.pop_front();
      check("ld_rdata", ld_rdata, popped);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      dmem[i]    = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    rst_n = 1'b0; if_req = 1'b1; if_addr = '0; ld_req = 1'b1; ld_we = 1'b1;
    ld_addr = '0; ld_wdata = '0; ld_done = 1'b0;
    model_reset();
    #12;
    check("rst_if_valid",  32'(if_valid),  32'h0);
    check("rst_ld_rvalid", 32'(ld_rvalid), 32'h0);
    check("rst_if_inst",   if_inst,        32'h0);
    check("rst_ld_rdata",  ld_rdata,       32'h0);
    check("rst_boot_done", 32'(boot_done), 32'h0);
    check("rst_mem_ce",    32'(mem_ce),    32'h0);
    check("rst_ld_gnt",    32'(ld_gnt),    32'h0);
    check("rst_stallreq",  32'(stallreq),  32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Boot image writes with a fetch pending: fetch stays stalled.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h4, 1'b1, 1'b1, 32'(i * 4), 32'h1111_1111 * 32'(i + 1), 1'b0);
    step(1'b1, 32'h4, 1'b0, 1'b0, '0, '0, 1'b1);

    // Single fetch in RUN.
    step(1'b1, 32'h4, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, '0,    1'b0, 1'b0, '0, '0, 1'b0);

    // Both requesting continuously: L,L,L,L,F repeating.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h8, 1'b1, 1'b0, 32'((i % 4) * 4), '0, 1'b0);
      check("burst_pat", 32'(obs_ld_gnt), 32'((i % 5) != 4));
    end

    // Loader read alone; ld_done in RUN is ignored.
    step(1'b0, '0, 1'b1, 1'b0, 32'h8, '0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, '0,    '0, 1'b0);

    // Fetch response pending, then reset.
    step(1'b1, 32'hC, 1'b0, 1'b0, '0, '0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_if_valid",  32'(if_valid),  32'h0);
    check("midrst_boot_done", 32'(boot_done), 32'h0);
    check("midrst_ld_gnt",    32'(ld_gnt),    32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h4, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b1, 32'h4, 1'b0, 1'b0, '0, '0, 1'b0);

    // Write together with ld_done in BOOT, then fetch the new word.
    step(1'b0, '0,     1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1);
    step(1'b1, 32'h10, 1'b0, 1'b0, '0,     '0,            1'b0);
    step(1'b0, '0,     1'b0, 1'b0, '0,     '0,            1'b0);
    check("queues_drained", 32'(if_q.size() + ld_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
